// File: rtl/gol_pkg.sv
// Shared game-of-life definitions: seeder state encoding, default board size
// and the cell value constants used by the grid, the engine and the seeder.
package gol_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } seed_state_t;

  localparam int GOL_COLS = 64;
  localparam int GOL_ROWS = 48;

  localparam logic CELL_ALIVE = 1'b1;
  localparam logic CELL_DEAD  = 1'b0;

endpackage

// File: rtl/board_seed_ctrl_rnd_gather.sv
// Collects DENS_BITS consecutive random bits into one threshold sample.
// acc_next already includes the current bit, so the final sample is usable on the last shift.
module rnd_gather #(
  parameter int DENS_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 shift,
  input  logic                 rnd_bit,
  output logic [DENS_BITS-1:0] acc_next,
  output logic                 last
);

  localparam int CNT_W = $clog2(DENS_BITS);

  logic [DENS_BITS-1:0] acc_q;
  logic [CNT_W-1:0]     cnt_q;

  assign acc_next = {acc_q[DENS_BITS-2:0], rnd_bit};
  assign last     = (cnt_q == CNT_W'(DENS_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (shift) begin
      acc_q <= acc_next;
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/board_seed_ctrl.sv
// Seeds the cell memory with a random board: DENS_BITS LFSR bits per cell are
// compared against a latched density and written row-major to the cell RAM.
module board_seed_ctrl
  import gol_pkg::*;
#(
  parameter int COLS      = GOL_COLS,
  parameter int ROWS      = GOL_ROWS,
  parameter int ADDR_W    = 12,
  parameter int DENS_BITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [DENS_BITS-1:0] i_density,
  input  logic                 i_rnd_bit,
  output logic                 o_wr_en,
  input  logic                 i_wr_ready,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic                 o_wr_data,
  output logic                 o_busy,
  output logic                 o_done,
  output seed_state_t          dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  // Write port: o_wr_en, o_wr_addr and o_wr_data are held stable while o_wr_en
  // is high; a write transfers on every posedge where o_wr_en and i_wr_ready are both 1.

  seed_state_t          state_q, state_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [DENS_BITS-1:0] dens_q, dens_d;

  logic                 gather_clear;
  logic                 gather_shift;
  logic [DENS_BITS-1:0] acc_next;
  logic                 gather_last;

  rnd_gather #(
    .DENS_BITS(DENS_BITS)
  ) u_gather (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .clear    (gather_clear),
    .shift    (gather_shift),
    .rnd_bit  (i_rnd_bit),
    .acc_next (acc_next),
    .last     (gather_last)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= CELL_DEAD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dens_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dens_q  <= dens_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    data_d       = data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    dens_d       = dens_q;
    gather_clear = 1'b0;
    gather_shift = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          dens_d       = i_density;
          addr_d       = '0;
          gather_clear = 1'b1;
          busy_d       = 1'b1;
          state_d      = S_GATHER;
        end
      end
      S_GATHER: begin
        gather_shift = 1'b1;
        if (gather_last) begin
          // Strict less-than: density 0 gives an all-dead board, all-alive is unreachable.
          data_d  = (acc_next < dens_q) ? CELL_ALIVE : CELL_DEAD;
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_wr_ready) begin
          wr_en_d = 1'b0;
          if (addr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_GATHER;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything except an idle board; the address is left as is.
    if (i_abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      wr_en_d      = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      gather_shift = 1'b0;
    end
  end

  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = addr_q;
  assign o_wr_data = data_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_board_seed_ctrl.sv
// Directed bench for board_seed_ctrl on a 4x2 board with 4 random bits per cell.
module tb_board_seed_ctrl;
  import gol_pkg::*;

  localparam int COLS      = 4;
  localparam int ROWS      = 2;
  localparam int ADDR_W    = 3;
  localparam int DENS_BITS = 4;
  localparam int CELLS     = COLS * ROWS;

  typedef struct {
    int              cyc;
    logic [ADDR_W-1:0] addr;
    logic            data;
  } trace_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 abort = 1'b0;
  logic [DENS_BITS-1:0] density = '0;
  logic                 rnd_bit = 1'b0;
  logic                 wr_en;
  logic                 wr_ready = 1'b1;
  logic [ADDR_W-1:0]    wr_addr;
  logic                 wr_data;
  logic                 busy;
  logic                 done;
  seed_state_t          state;

  int checks = 0;
  int failures = 0;

  logic [ADDR_W:0] exp_q[$];
  logic [ADDR_W:0] got_q[$];
  trace_t          trace_q[$];

  int rnd_mode = 0;
  int stall_addr = -1;
  int stall_len = 0;
  int xs_cyc1 = -1;
  int xs_cyc2 = -1;
  int first_wr_cyc;
  int done_cyc;
  int n_done;
  logic busy_first;
  logic busy_at_done;

  board_seed_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DENS_BITS(DENS_BITS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_density(density), .i_rnd_bit(rnd_bit), .o_wr_en(wr_en),
    .i_wr_ready(wr_ready), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .dbg_state(state)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_rnd();
    case (rnd_mode)
      1:       rnd_bit = 1'b0;
      2:       rnd_bit = 1'b1;
      default: rnd_bit = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Entered at a negedge; returns at the negedge after the start edge (cycle 1).
  task automatic do_start(input logic [DENS_BITS-1:0] d);
    density = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic build_exp(input logic d);
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back({ADDR_W'(i), d});
  endtask

  // Runs one seeding pass and records accepted writes, write trace and done timing.
  task automatic collect_run(input logic [DENS_BITS-1:0] dens, input int max_cyc);
    int cyc;
    int stall_cnt;
    got_q.delete();
    trace_q.delete();
    first_wr_cyc = -1;
    done_cyc = -1;
    n_done = 0;
    busy_at_done = 1'b1;
    stall_cnt = 0;
    drive_rnd();
    do_start(dens);
    density = ~dens;
    cyc = 1;
    busy_first = busy;
    while (cyc <= max_cyc) begin
      start = (cyc == xs_cyc1) || (cyc == xs_cyc2);
      if (wr_en && int'(wr_addr) == stall_addr && stall_cnt < stall_len) begin
        wr_ready = 1'b0;
        stall_cnt++;
      end else begin
        wr_ready = 1'b1;
      end
      if (wr_en) begin
        trace_q.push_back('{cyc, wr_addr, wr_data});
        if (wr_ready) got_q.push_back({wr_addr, wr_data});
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      drive_rnd();
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    wr_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0h expected 0", {wr_en, wr_addr, wr_data, busy, done});
    end
    checks++;
    if (state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state %0d busy %0b expected idle/0", state, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen_done;
    rnd_mode = 1;
    wr_ready = 1'b1;
    do_start(4'd15);
    for (int c = 1; c < 15; c++) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 3'd2 || wr_data !== 1'b1) begin
      failures++;
      $display("FAIL mid_write_setup: en %0b addr %0d data %0b expected 1/2/1", wr_en, wr_addr, wr_data);
    end
    wr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({wr_en, wr_addr, wr_data, busy, done} !== '0 || state !== S_IDLE) begin
      failures++;
      $display("FAIL mid_write_reset: outs %0h state %0d expected 0/idle",
               {wr_en, wr_addr, wr_data, busy, done}, state);
    end
    seen_done = 0;
    wr_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || wr_en) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      failures++;
      $display("FAIL mid_write_quiet: got %0d done/write cycles expected 0", seen_done);
    end
  endtask

  task automatic test_density_zero();
    rnd_mode = 0;
    collect_run(4'd0, 45);
    build_exp(CELL_DEAD);
    checks++;
    if (got_q.size() !== CELLS) begin
      failures++;
      $display("FAIL dz_count: got %0d writes expected %0d", got_q.size(), CELLS);
    end
    for (int i = 0; i < CELLS && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL dz_write%0d: got %0h expected %0h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first_wr_cyc !== 5) begin
      failures++;
      $display("FAIL dz_first_wr: got cycle %0d expected 5", first_wr_cyc);
    end
    checks++;
    if (done_cyc !== 41 || n_done !== 1) begin
      failures++;
      $display("FAIL dz_done: got cycle %0d count %0d expected 41/1", done_cyc, n_done);
    end
    checks++;
    if (busy_first !== 1'b1 || busy_at_done !== 1'b0) begin
      failures++;
      $display("FAIL dz_busy: got %0b/%0b expected 1/0", busy_first, busy_at_done);
    end
  endtask

  task automatic test_density_extremes();
    rnd_mode = 1;
    collect_run(4'd15, 45);
    build_exp(CELL_ALIVE);
    checks++;
    if (got_q !== exp_q) begin
      failures++;
      $display("FAIL d15_rnd0: got %p expected %p", got_q, exp_q);
    end
    rnd_mode = 2;
    collect_run(4'd15, 45);
    build_exp(CELL_DEAD);
    checks++;
    if (got_q !== exp_q) begin
      failures++;
      $display("FAIL d15_rnd1: got %p expected %p", got_q, exp_q);
    end
    rnd_mode = 1;
    collect_run(4'd1, 45);
    build_exp(CELL_ALIVE);
    checks++;
    if (got_q !== exp_q) begin
      failures++;
      $display("FAIL d1_rnd0: got %p expected %p", got_q, exp_q);
    end
  endtask

  task automatic test_backpressure();
    int n3;
    int bad;
    rnd_mode = 1;
    stall_addr = 3;
    stall_len = 5;
    collect_run(4'd15, 50);
    stall_addr = -1;
    build_exp(CELL_ALIVE);
    checks++;
    if (got_q !== exp_q) begin
      failures++;
      $display("FAIL bp_writes: got %p expected %p", got_q, exp_q);
    end
    n3 = 0;
    bad = 0;
    foreach (trace_q[i]) begin
      if (trace_q[i].addr == 3'd3) begin
        if (trace_q[i].cyc != 20 + n3 || trace_q[i].data !== 1'b1) bad++;
        n3++;
      end
    end
    checks++;
    if (n3 !== 6 || bad !== 0) begin
      failures++;
      $display("FAIL bp_hold: got %0d held cycles %0d unstable expected 6/0", n3, bad);
    end
    checks++;
    if (done_cyc !== 46) begin
      failures++;
      $display("FAIL bp_done: got cycle %0d expected 46", done_cyc);
    end
  endtask

  task automatic test_abort();
    int stray;
    rnd_mode = 1;
    wr_ready = 1'b1;
    do_start(4'd15);
    for (int c = 1; c < 11; c++) @(negedge clk);
    checks++;
    if (state !== S_GATHER || wr_addr !== 3'd2) begin
      failures++;
      $display("FAIL abort_setup: state %0d addr %0d expected gather/2", state, wr_addr);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0 || state !== S_IDLE) begin
      failures++;
      $display("FAIL abort_next: busy %0b en %0b done %0b state %0d expected 0/0/0/idle",
               busy, wr_en, done, state);
    end
    stray = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wr_en || done || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL abort_quiet: got %0d active cycles expected 0", stray);
    end
    collect_run(4'd15, 45);
    build_exp(CELL_ALIVE);
    checks++;
    if (got_q !== exp_q || done_cyc !== 41) begin
      failures++;
      $display("FAIL abort_restart: got %p done %0d expected %p done 41", got_q, done_cyc, exp_q);
    end
  endtask

  task automatic test_start_ignored();
    rnd_mode = 1;
    density = 4'd15;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (state !== S_IDLE || busy !== 1'b0) begin
      failures++;
      $display("FAIL start_abort_idle: state %0d busy %0b expected idle/0", state, busy);
    end
    xs_cyc1 = 7;
    xs_cyc2 = 23;
    collect_run(4'd0, 45);
    xs_cyc1 = -1;
    xs_cyc2 = -1;
    build_exp(CELL_DEAD);
    checks++;
    if (got_q !== exp_q) begin
      failures++;
      $display("FAIL busy_start_writes: got %p expected %p", got_q, exp_q);
    end
    checks++;
    if (first_wr_cyc !== 5 || done_cyc !== 41 || n_done !== 1) begin
      failures++;
      $display("FAIL busy_start_timing: first %0d done %0d count %0d expected 5/41/1",
               first_wr_cyc, done_cyc, n_done);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_write();
    test_density_zero();
    test_density_extremes();
    test_backpressure();
    test_abort();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
